round_robin_lock_arbiter: RTL and testbench
===========================================

// Module: round_robin_lock_arbiter
// PURPOSE
//   Shares one resource between REQUESTERS clients with a round-robin arbiter.
//   A winner locks the resource until it releases it, drops its request, or hits a hold timeout.
//   The grant is registered. It is driven as a binary index and as a one-hot vector.
//   The one-hot vector comes from the binary_to_onehot encoder.
//   Placed in front of shared datapath resources: buses, memory ports, encoder/decoder engines.
// PARAMETERS
//   REQUESTERS  4                                     number of clients, >=2
//   INDEX_WIDTH $clog2(REQUESTERS) (min 1)            width of the binary grant index
//   MAX_HOLD    16                                    max cycles a grant is held; 0 = unlimited
//   HOLD_WIDTH  $clog2(MAX_HOLD+1) (min 1)            width of the hold counter
// PORTS
//   clock        input   1            single clock, rising edge
//   resetn       input   1            asynchronous active-low reset
//   requests     input   REQUESTERS   per-client request, level
//   releases     input   REQUESTERS   per-client release pulse; only the granted bit is honoured
//   grant        output  REQUESTERS   one-hot grant, all zeros when idle
//   grant_valid  output  1            a grant is active
//   grant_index  output  INDEX_WIDTH  binary index of the granted client, 0 when idle
//   timeout      output  1            one-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
//   Reset values: grant=0, grant_valid=0, grant_index=0, timeout=0.
//     Internal: pointer=0, hold_count=0, state=IDLE.
//   Reset is asynchronous to all flops. Asserting resetn low mid-grant clears the grant immediately.
//   States:
//     IDLE    : no grant.
//               If requests!=0, choose the first set bit scanning from pointer upward, wrapping at REQUESTERS-1.
//               Register the choice, go to GRANTED. Grant is visible on the cycle after the request is seen (latency 1).
//     GRANTED : grant held stable. hold_count increments every cycle, starting at 1 on the first grant cycle.
//   Ending a grant (evaluated every GRANTED cycle, highest priority first):
//     1. releases[grant_index]=1 or requests[grant_index]=0 -> normal end, timeout=0.
//     2. MAX_HOLD!=0 and hold_count==MAX_HOLD -> revoke, timeout=1 for one cycle.
//   On either end:
//     - next cycle: grant=0, grant_valid=0, grant_index=0, hold_count=0, state=IDLE.
//     - pointer = grant_index+1, wrapping to 0 after REQUESTERS-1.
//     - One idle bubble is guaranteed. Next grant is visible 2 cycles after the end cycle at the earliest.
//   Release and timeout in the same cycle: release wins, no timeout pulse.
//   releases bits of non-granted clients are ignored in every state. releases is ignored in IDLE.
//   grant_index values >= REQUESTERS (non-power-of-2 REQUESTERS) never occur.
//     The pointer wraps at REQUESTERS-1, not at 2**INDEX_WIDTH-1.
//   grant == (grant_valid ? 1<<grant_index : 0) on every cycle. This invariant is asserted.
//   The hold counter saturates at MAX_HOLD and never wraps. It is unused when MAX_HOLD=0.
// STRUCTURE
//   Shared package/header: state encoding (IDLE=1'b0, GRANTED=1'b1).
//   Single sub-module: binary_to_onehot (WIDTH_BINARY=INDEX_WIDTH, WIDTH_ONEHOT=REQUESTERS).
//     Input is the registered grant_index; output is gated by grant_valid to form grant.
//   Priority scan: rotate requests by pointer, take the lowest set bit, add pointer modulo REQUESTERS.
//     Combinational, inside this module.
// TESTING
//   1. Reset then requests=4'b0101 steady.
//      -> cycle 1: grant=0001, index 0. After releases=0001: 1 idle cycle, then grant=0100, index 2.
//   2. All 4 requesting, each releases after 3 cycles.
//      -> grant order 0,1,2,3,0. Each grant 3 cycles with a 1-cycle bubble between grants.
//   3. MAX_HOLD=16, client 1 holds with no release.
//      -> timeout pulses on the cycle after hold_count==16. Grant drops. The next grant goes to client 2 if it is requesting.
//   4. Release and timeout in the same cycle.
//      -> timeout stays 0. Then releases=1110 while client 0 is granted -> ignored, grant held.
//   5. REQUESTERS=3, pointer at 2, requests=3'b011.
//      -> grant index 0 (wrap). grant_index never reaches 3.
//   6. resetn low mid-grant -> grant, grant_valid, grant_index and timeout are 0 immediately.
//      After resetn rises, the first grant restarts the scan from pointer 0.

Source files
------------

// File: rtl/round_robin_lock_arbiter_pkg.sv
// Shared definitions for the round-robin lock arbiter.
// The FSM state encoding is fixed so existing netlists and probes see the same values.
package round_robin_lock_arbiter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/round_robin_lock_arbiter_binary_to_onehot.sv
// Binary index to one-hot decoder.
// Any index with no matching output bit decodes to all zeros.
module binary_to_onehot
  import round_robin_lock_arbiter_pkg::*;
#(
  parameter int WIDTH_BINARY = 2,
  parameter int WIDTH_ONEHOT = 4
) (
  input  logic [WIDTH_BINARY-1:0] binary,
  output logic [WIDTH_ONEHOT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < WIDTH_ONEHOT; i++) begin
      onehot[i] = (binary == WIDTH_BINARY'(i));
    end
  end

endmodule

// File: rtl/round_robin_lock_arbiter.sv
// Round-robin arbiter that locks the resource to one winner until release, request drop
// or hold timeout. The grant index is registered; the one-hot grant is decoded from it.
module round_robin_lock_arbiter
  import round_robin_lock_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = 4,
  parameter int INDEX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1,
  parameter int MAX_HOLD    = 16,
  parameter int HOLD_WIDTH  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [REQUESTERS-1:0]  requests,
  input  logic [REQUESTERS-1:0]  releases,
  output logic [REQUESTERS-1:0]  grant,
  output logic                   grant_valid,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   timeout
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(REQUESTERS - 1);
  localparam logic [HOLD_WIDTH-1:0]  HOLD_LIMIT = HOLD_WIDTH'(MAX_HOLD);
  localparam logic [HOLD_WIDTH-1:0]  HOLD_FIRST = (MAX_HOLD != 0) ? HOLD_WIDTH'(1) : '0;

  arb_state_t               state;
  logic [INDEX_WIDTH-1:0]   pointer;
  logic [HOLD_WIDTH-1:0]    hold_count;
  logic [INDEX_WIDTH-1:0]   winner;
  logic [INDEX_WIDTH-1:0]   next_pointer;
  logic [INDEX_WIDTH-1:0]   up_index;
  logic [INDEX_WIDTH-1:0]   any_index;
  logic                     up_found;
  logic                     any_found;
  logic                     end_normal;
  logic                     end_timeout;
  logic [REQUESTERS-1:0]    index_onehot;

  // Rotate-by-pointer scan done as two masked lowest-bit searches: the first request at or
  // above the pointer wins, otherwise the lowest request overall (the wrapped part).
  always_comb begin
    up_found  = 1'b0;
    any_found = 1'b0;
    up_index  = '0;
    any_index = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (requests[i] && !any_found) begin
        any_found = 1'b1;
        any_index = INDEX_WIDTH'(i);
      end
      if (requests[i] && !up_found && (INDEX_WIDTH'(i) >= pointer)) begin
        up_found = 1'b1;
        up_index = INDEX_WIDTH'(i);
      end
    end
    winner = up_found ? up_index : any_index;
  end

  assign end_normal   = releases[grant_index] | ~requests[grant_index];
  assign end_timeout  = (MAX_HOLD != 0) && (hold_count == HOLD_LIMIT);
  assign next_pointer = (grant_index == LAST_INDEX) ? '0 : grant_index + 1'b1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      pointer     <= '0;
      hold_count  <= '0;
      grant_valid <= 1'b0;
      grant_index <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|requests) begin
            state       <= GRANTED;
            grant_valid <= 1'b1;
            grant_index <= winner;
            hold_count  <= HOLD_FIRST;
          end
        end
        GRANTED: begin
          if (end_normal || end_timeout) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_index <= '0;
            hold_count  <= '0;
            pointer     <= next_pointer;
            timeout     <= ~end_normal;
          end else if ((MAX_HOLD != 0) && (hold_count != HOLD_LIMIT)) begin
            hold_count <= hold_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  binary_to_onehot #(
    .WIDTH_BINARY(INDEX_WIDTH),
    .WIDTH_ONEHOT(REQUESTERS)
  ) u_onehot (
    .binary(grant_index),
    .onehot(index_onehot)
  );

  assign grant = index_onehot & {REQUESTERS{grant_valid}};

  grant_matches_index: assert property (@(posedge clock) disable iff (!resetn)
    grant == (grant_valid ? (REQUESTERS'(1) << grant_index) : '0));

endmodule

// File: tb/tb_round_robin_lock_arbiter.sv
// Bench for round_robin_lock_arbiter: a 4-client/hold-16 instance and a 3-client/hold-4
// instance, each tracked cycle by cycle by a behavioural model plus directed literal checks.
module tb_round_robin_lock_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] req4, rel4, g4;
  logic [2:0] req3, rel3, g3;
  logic [1:0] i4, i3;
  logic       v4, t4, v3, t3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  round_robin_lock_arbiter #(.REQUESTERS(4), .MAX_HOLD(16)) dut4 (
    .clock(clock), .resetn(resetn), .requests(req4), .releases(rel4),
    .grant(g4), .grant_valid(v4), .grant_index(i4), .timeout(t4)
  );

  round_robin_lock_arbiter #(.REQUESTERS(3), .MAX_HOLD(4)) dut3 (
    .clock(clock), .resetn(resetn), .requests(req3), .releases(rel3),
    .grant(g3), .grant_valid(v3), .grant_index(i3), .timeout(t3)
  );

  // Model state per instance: 0 -> 4 clients / hold 16, 1 -> 3 clients / hold 4.
  int NREQ  [2] = '{4, 3};
  int NHOLD [2] = '{16, 4};
  bit m_valid [2];
  bit m_to    [2];
  int m_owner [2];
  int m_ptr   [2];
  int m_held  [2];

  function automatic bit req_bit(input int n, input int k);
    return (n == 0) ? req4[k] : req3[k];
  endfunction

  function automatic bit rel_bit(input int n, input int k);
    return (n == 0) ? rel4[k] : rel3[k];
  endfunction

  task automatic model_step(input int n);
    int r, c;
    bit picked;
    r = NREQ[n];
    m_to[n] = 1'b0;
    if (!m_valid[n]) begin
      picked = 1'b0;
      for (int k = 0; k < r; k++) begin
        c = (m_ptr[n] + k) % r;
        if (!picked && req_bit(n, c)) begin
          picked     = 1'b1;
          m_owner[n] = c;
          m_valid[n] = 1'b1;
          m_held[n]  = 1;
        end
      end
    end else if (rel_bit(n, m_owner[n]) || !req_bit(n, m_owner[n]) ||
                 (NHOLD[n] != 0 && m_held[n] == NHOLD[n])) begin
      m_to[n]    = !(rel_bit(n, m_owner[n]) || !req_bit(n, m_owner[n]));
      m_ptr[n]   = (m_owner[n] + 1) % r;
      m_valid[n] = 1'b0;
      m_owner[n] = 0;
      m_held[n]  = 0;
    end else begin
      m_held[n] = m_held[n] + 1;
    end
  endtask

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 2; n++) begin
        m_valid[n] = 1'b0; m_to[n] = 1'b0; m_owner[n] = 0; m_ptr[n] = 0; m_held[n] = 0;
      end
    end else begin
      for (int n = 0; n < 2; n++) model_step(n);
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    check("m4_grant", int'(g4), m_valid[0] ? (1 << m_owner[0]) : 0);
    check("m4_valid", int'(v4), int'(m_valid[0]));
    check("m4_index", int'(i4), m_owner[0]);
    check("m4_timeout", int'(t4), int'(m_to[0]));
    check("m3_grant", int'(g3), m_valid[1] ? (1 << m_owner[1]) : 0);
    check("m3_valid", int'(v3), int'(m_valid[1]));
    check("m3_index", int'(i3), m_owner[1]);
    check("m3_timeout", int'(t3), int'(m_to[1]));
  end

  initial begin
    resetn = 1'b0;
    req4 = '0; rel4 = '0; req3 = '0; rel3 = '0;
    repeat (2) @(negedge clock);
    check("reset_grant", int'(g4), 0);
    check("reset_valid", int'(v4), 0);
    check("reset_index", int'(i4), 0);
    check("reset_timeout", int'(t4), 0);

    // Two requesters, release, bubble, next in rotation.
    resetn = 1'b1; req4 = 4'b0101;
    @(negedge clock);
    check("t1_first_grant", int'(g4), 4'b0001);
    check("t1_first_index", int'(i4), 0);
    rel4 = 4'b0001;
    @(negedge clock);
    rel4 = '0;
    check("t1_bubble", int'(v4), 0);
    @(negedge clock);
    check("t1_second_grant", int'(g4), 4'b0100);
    check("t1_second_index", int'(i4), 2);
    check("t1_model_pin", m_owner[0], 2);

    // Client 1 holds to the limit; pointer then moves to client 2.
    req4 = 4'b0110; rel4 = 4'b0100;
    @(negedge clock);
    rel4 = '0;
    check("t3_bubble", int'(g4), 0);
    @(negedge clock);
    check("t3_grant1", int'(g4), 4'b0010);
    repeat (15) @(negedge clock);
    check("t3_last_held", int'(g4), 4'b0010);
    check("t3_no_early_to", int'(t4), 0);
    @(negedge clock);
    check("t3_revoked", int'(g4), 0);
    check("t3_timeout", int'(t4), 1);
    @(negedge clock);
    check("t3_next_grant", int'(g4), 4'b0100);
    check("t3_to_cleared", int'(t4), 0);

    // Release on the limit cycle beats the timeout.
    repeat (15) @(negedge clock);
    check("t4_still_held", int'(g4), 4'b0100);
    rel4 = 4'b0100;
    @(negedge clock);
    rel4 = '0; req4 = 4'b0001;
    check("t4_no_timeout", int'(t4), 0);
    check("t4_dropped", int'(g4), 0);
    @(negedge clock);
    check("t4_grant0", int'(g4), 4'b0001);
    rel4 = 4'b1110;
    @(negedge clock);
    rel4 = '0;
    check("t4_foreign_rel", int'(g4), 4'b0001);

    // Asynchronous reset mid-grant; scan restarts from pointer 0.
    #2 resetn = 1'b0;
    #1;
    check("t6_grant", int'(g4), 0);
    check("t6_valid", int'(v4), 0);
    check("t6_index", int'(i4), 0);
    check("t6_timeout", int'(t4), 0);
    @(negedge clock);
    resetn = 1'b1; req4 = 4'b1010;
    @(negedge clock);
    check("t6_restart", int'(i4), 1);

    // All four requesting, three-cycle grants, order 0,1,2,3,0.
    #2 resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1; req4 = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        check("t2_order", int'(i4), g % 4);
        check("t2_onehot", int'(g4), 1 << (g % 4));
      end
      rel4 = 4'(1 << (g % 4));
      @(negedge clock);
      rel4 = '0;
      check("t2_bubble", int'(v4), 0);
    end

    // Three clients, pointer at 2, wrap to client 0.
    req4 = '0; req3 = 3'b010;
    @(negedge clock);
    check("t5_first", int'(i3), 1);
    rel3 = 3'b010;
    @(negedge clock);
    rel3 = '0; req3 = 3'b011;
    @(negedge clock);
    check("t5_wrap_index", int'(i3), 0);
    check("t5_wrap_grant", int'(g3), 3'b001);

    // Randomized traffic on both instances with occasional asynchronous resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      req4 ^= 4'($urandom) & 4'($urandom) & 4'($urandom);
      req3 ^= 3'($urandom) & 3'($urandom) & 3'($urandom);
      rel4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      rel3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b0;
      if ($urandom_range(0, 499) == 0) begin
        #3 resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
      end
    end

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
